maze_walker: RTL

MAZE_WALKER -- requirements
Module: maze_walker

---
 rtl/maze_walker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/maze_walker.sv
// maze_walker: steps a walker around an 8x8 map, one registered ROM row lookup per in-grid move.
// Define WALKER_MOVECNT_EN to add the saturating move_cnt_o counter of successful moves.
module maze_walker #(
  parameter logic [2:0] START_X = 3'd2,
  parameter logic [2:0] START_Y = 3'd0,
  parameter logic [2:0] GOAL_X  = 3'd4,
  parameter logic [2:0] GOAL_Y  = 3'd7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       move_valid_i,
  input  logic [1:0] move_dir_i,
  output logic       move_ready_o,
  output logic       rom_en_o,
  output logic [2:0] rom_addr_o,
  input  logic [7:0] rom_data_i,
  output logic [2:0] pos_x_o,
  output logic [2:0] pos_y_o,
  output logic       res_valid_o,
  output logic       res_moved_o,
  output logic       at_goal_o
`ifdef WALKER_MOVECNT_EN
  ,
  output logic [7:0] move_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2
  } state_t;

  localparam logic START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

  state_t     state_q, state_d;
  logic [2:0] tgt_x_q, tgt_x_d;
  logic [2:0] tgt_y_q, tgt_y_d;
  logic [2:0] pos_x_q, pos_x_d;
  logic [2:0] pos_y_q, pos_y_d;
  logic       res_valid_q, res_valid_d;
  logic       res_moved_q, res_moved_d;
  logic       at_goal_q;
  logic [3:0] step_x, step_y;
  logic       off_grid;
  logic       accept;
  logic       cell_open;

  assign accept = move_valid_i & move_ready_o;

  // One extra bit so that stepping below 0 or above 7 shows up in bit 3.
  always_comb begin
    step_x = {1'b0, pos_x_q};
    step_y = {1'b0, pos_y_q};
    case (move_dir_i)
      2'b00:   step_y = {1'b0, pos_y_q} - 4'd1;
      2'b01:   step_x = {1'b0, pos_x_q} + 4'd1;
      2'b10:   step_y = {1'b0, pos_y_q} + 4'd1;
      default: step_x = {1'b0, pos_x_q} - 4'd1;
    endcase
  end

  assign off_grid  = step_x[3] | step_y[3];
  assign cell_open = rom_data_i[3'd7 - tgt_x_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !off_grid) state_d = READ;
      READ:    state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    move_ready_o = (state_q == IDLE) && !rst_i;
    rom_en_o     = (state_q == READ);
    rom_addr_o   = (state_q == READ) ? tgt_y_q : 3'd0;
  end

  always_comb begin
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    res_valid_d = 1'b0;
    res_moved_d = 1'b0;
    if (state_q == IDLE && accept) begin
      tgt_x_d = step_x[2:0];
      tgt_y_d = step_y[2:0];
      if (off_grid) res_valid_d = 1'b1;
    end
    if (state_q == EVAL) begin
      res_valid_d = 1'b1;
      if (cell_open) begin
        pos_x_d     = tgt_x_q;
        pos_y_d     = tgt_y_q;
        res_moved_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgt_x_q     <= START_X;
      tgt_y_q     <= START_Y;
      pos_x_q     <= START_X;
      pos_y_q     <= START_Y;
      res_valid_q <= 1'b0;
      res_moved_q <= 1'b0;
      at_goal_q   <= START_AT_GOAL;
    end else begin
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      res_valid_q <= res_valid_d;
      res_moved_q <= res_moved_d;
      at_goal_q   <= (pos_x_d == GOAL_X) && (pos_y_d == GOAL_Y);
    end
  end

`ifdef WALKER_MOVECNT_EN
  logic [7:0] move_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      move_cnt_q <= 8'd0;
    end else if (res_valid_d && res_moved_d && move_cnt_q != 8'hFF) begin
      move_cnt_q <= move_cnt_q + 8'd1;
    end
  end

  assign move_cnt_o = move_cnt_q;
`endif

  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign res_valid_o = res_valid_q;
  assign res_moved_o = res_moved_q;
  assign at_goal_o   = at_goal_q;

endmodule
